oh_parity_chk: RTL and testbench

OH_PARITY_CHK -- requirements
Module: oh_parity_chk

---
 rtl/oh_parity_pkg.sv | 12 +
 rtl/oh_parity_reduce.sv | 11 +
 rtl/oh_parity_chk.sv | 107 ++++++++++
 tb/tb_oh_parity_chk.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/oh_parity_pkg.sv
// Shared constants and types for the parity checker slice.
package oh_parity_pkg;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/oh_parity_reduce.sv
// Combinational XOR reduction of a data word.
module oh_parity_reduce #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_data,
  output logic         o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/oh_parity_chk.sv
// Single-stage registered parity checker with valid/ready handshake,
// sticky error flag and saturating error counter.
module oh_parity_chk
  import oh_parity_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 16,
  parameter int ODD = PARITY_EVEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_parity,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_err,
  input  logic          clear,
  output logic          err_sticky,
  output logic [CW-1:0] err_count
);

  localparam logic          EXP_PAR = (ODD == PARITY_ODD) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  fill_state_e r_state;
  fill_state_e w_state_nxt;
  logic        w_xor;
  logic        w_err;
  logic        w_accept;
  logic        w_deliver;
  logic        w_err_acc;

  oh_parity_reduce #(.N(N)) u_reduce (
    .i_data   (in_data),
    .o_parity (w_xor)
  );

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;
  assign w_err     = ((w_xor ^ in_parity) != EXP_PAR);
  assign w_err_acc = w_accept & w_err;

  // Fill-state next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_deliver && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Fill-state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output word register, loaded on every acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= {N{1'b0}};
      out_err  <= 1'b0;
    end else if (w_accept) begin
      out_data <= in_data;
      out_err  <= w_err;
    end
  end

  // Error statistics; an error accepted on the clear edge survives the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_count  <= {CW{1'b0}};
    end else if (clear) begin
      err_sticky <= w_err_acc;
      err_count  <= w_err_acc ? CNT_ONE : {CW{1'b0}};
    end else if (w_err_acc) begin
      err_sticky <= 1'b1;
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_oh_parity_chk.sv
// Scoreboard bench: an even-parity CW=2 instance and an odd-parity CW=16 instance share stimulus.
module tb_oh_parity_chk;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       eo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_parity;
  logic        out_ready;
  logic        clear;
  logic [7:0]  in_data;

  logic        in_ready, out_valid, out_err, err_sticky;
  logic [7:0]  out_data;
  logic [1:0]  err_count;
  logic        in_ready_o, out_valid_o, out_err_o, err_sticky_o;
  logic [7:0]  out_data_o;
  logic [15:0] err_count_o;

  int   n_err = 0;
  int   n_chk = 0;
  bit   m_full;
  bit   m_stk, m_stk_o;
  int   m_cnt, m_cnt_o;
  exp_t sbq[$];

  always #5 clk = ~clk;

  oh_parity_chk #(.N(8), .CW(2), .ODD(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .clear(clear), .err_sticky(err_sticky), .err_count(err_count)
  );

  oh_parity_chk #(.N(8), .CW(16), .ODD(1)) u_odd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid_o),
    .out_ready(out_ready), .out_data(out_data_o), .out_err(out_err_o),
    .clear(clear), .err_sticky(err_sticky_o), .err_count(err_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic p,
                     input logic rdy, input logic clr);
    exp_t e;
    logic acc, dlv, ee, eo;
    @(negedge clk);
    in_valid = v; in_data = d; in_parity = p; out_ready = rdy; clear = clr;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_full || rdy));
    chk("in_ready_odd", 32'(in_ready_o), 32'(!m_full || rdy));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_valid_odd", 32'(out_valid_o), 32'(m_full));
    if (m_full) begin
      chk("sb_depth", 32'(sbq.size()), 32'(1));
      if (sbq.size() > 0) begin
        e = sbq[0];
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_err", 32'(out_err), 32'(e.e));
        chk("out_data_odd", 32'(out_data_o), 32'(e.d));
        chk("out_err_odd", 32'(out_err_o), 32'(e.eo));
        if (rdy) e = sbq.pop_front();
      end
    end
    acc = v && (!m_full || rdy);
    dlv = m_full && rdy;
    ee  = ((^d) ^ p) != 1'b0;
    eo  = ((^d) ^ p) != 1'b1;
    if (acc) begin
      e.d = d; e.e = ee; e.eo = eo;
      sbq.push_back(e);
    end
    m_full = acc ? 1'b1 : (dlv ? 1'b0 : m_full);
    if (clr) begin
      m_stk   = acc && ee;
      m_cnt   = (acc && ee) ? 1 : 0;
      m_stk_o = acc && eo;
      m_cnt_o = (acc && eo) ? 1 : 0;
    end else begin
      if (acc && ee) begin
        m_stk = 1'b1;
        if (m_cnt < 3) m_cnt++;
      end
      if (acc && eo) begin
        m_stk_o = 1'b1;
        if (m_cnt_o < 65535) m_cnt_o++;
      end
    end
    @(posedge clk);
    #1;
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("err_sticky", 32'(err_sticky), 32'(m_stk));
    chk("err_count_odd", 32'(err_count_o), 32'(m_cnt_o));
    chk("err_sticky_odd", 32'(err_sticky_o), 32'(m_stk_o));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_data"}, 32'(out_data), 32'(0));
    chk({tag, "_err"}, 32'(out_err), 32'(0));
    chk({tag, "_sticky"}, 32'(err_sticky), 32'(0));
    chk({tag, "_count"}, 32'(err_count), 32'(0));
    chk({tag, "_count_odd"}, 32'(err_count_o), 32'(0));
    chk({tag, "_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_parity = 1'b0;
    out_ready = 1'b0; clear = 1'b0;
    m_full = 1'b0; m_stk = 1'b0; m_stk_o = 1'b0; m_cnt = 0; m_cnt_o = 0;
    #12;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    // basic even/odd parity words
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // back-to-back stream, then a 3-cycle stall with a word waiting
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h30 + i), 1'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // saturation with CW=2, then clear
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // clear coinciding with an accepted error at count 2
    cyc(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);

    // build count to 3 and leave a word held
    cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(err_count), 32'(3));
    chk("pre_reset_full", 32'(out_valid), 32'(1));

    // asynchronous reset while FULL
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    m_full = 1'b0; m_stk = 1'b0; m_stk_o = 1'b0; m_cnt = 0; m_cnt_o = 0;
    sbq.delete();
    @(posedge clk);
    #1;
    chk_reset_state("held");
    #1;
    reset = 1'b0;

    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
